// File: rtl/mult_result_queue.sv
// mult_result_queue: completion and flow-control stage that sits behind pipe_mult.
// Launches are gated by a credit counter so every result that leaves the
// non-stallable multiplier is guaranteed a slot in the tagged result FIFO.
module mult_result_queue #(
    parameter int BIT_WIDTH = 32,
    parameter int STAGES    = 8,
    parameter int TAG_WIDTH = 5,
    parameter int DEPTH     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic [TAG_WIDTH-1:0] issue_tag_i,
    output logic                 issue_ready_o,
    output logic                 start_o,
    input  logic [BIT_WIDTH-1:0] product_i,
    input  logic                 done_i,
    output logic                 wb_valid_o,
    output logic [BIT_WIDTH-1:0] wb_data_o,
    output logic [TAG_WIDTH-1:0] wb_tag_o,
    input  logic                 wb_ready_i,
    output logic                 err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]     reserved_q, reserved_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic                 err_q, err_d;
    logic [STAGES-1:0]    tagValid_q;
    logic [TAG_WIDTH-1:0] tagPipe_q [STAGES];
    logic [BIT_WIDTH-1:0] dataMem_q [DEPTH];
    logic [TAG_WIDTH-1:0] tagMem_q  [DEPTH];

    logic                 issueFire;
    logic                 wbFire;
    logic                 expValid;
    logic [TAG_WIDTH-1:0] expTag;
    logic                 push;

    // A credit is consumed at launch and returned only when writeback pops.
    assign issue_ready_o = (reserved_q != DEPTH_C) & ~rst_i;
    assign start_o       = issue_valid_i & issue_ready_o;
    assign issueFire     = start_o;

    assign expValid = tagValid_q[STAGES-1];
    assign expTag   = tagPipe_q[STAGES-1];
    assign push     = expValid;

    // Head is shown ahead; outputs read as zero while the FIFO is empty.
    assign wb_valid_o = (count_q != '0);
    assign wbFire     = wb_valid_o & wb_ready_i;
    assign wb_data_o  = wb_valid_o ? dataMem_q[rdPtr_q] : '0;
    assign wb_tag_o   = wb_valid_o ? tagMem_q[rdPtr_q]  : '0;
    assign err_o      = err_q;

    // Next-state for credits, FIFO occupancy/pointers and the sticky error flag.
    always_comb begin
        reserved_d = reserved_q;
        count_d    = count_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        err_d      = err_q;

        case ({issueFire, wbFire})
            2'b10:   reserved_d = reserved_q + CNT_W'(1);
            2'b01:   reserved_d = reserved_q - CNT_W'(1);
            default: reserved_d = reserved_q;
        endcase

        case ({push, wbFire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (wbFire) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end

        // Either a result arrived with no op expected, or an expected op never showed.
        if (expValid ^ done_i) begin
            err_d = 1'b1;
        end
    end

    // Control state register; reset discards credits, FIFO contents and the error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reserved_q <= '0;
            count_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            count_q    <= count_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            err_q      <= err_d;
        end
    end

    // Shadow valid pipeline that mirrors the multiplier's occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tagValid_q <= '0;
        end else begin
            tagValid_q[0] <= start_o;
            for (int i = 1; i < STAGES; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
            end
        end
    end

    // Tag payload travels alongside the valid bits; it is only meaningful when valid.
    always_ff @(posedge clk_i) begin
        tagPipe_q[0] <= issue_tag_i;
        for (int i = 1; i < STAGES; i++) begin
            tagPipe_q[i] <= tagPipe_q[i-1];
        end
    end

    // Result storage; credits guarantee a free slot whenever an op emerges.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            dataMem_q[wrPtr_q] <= product_i;
            tagMem_q[wrPtr_q]  <= expTag;
        end
    end

endmodule

// File: tb/tb_mult_result_queue.sv
// Self-checking bench for mult_result_queue with a behavioural pipe_mult and a
// transaction-level reference model (credits, in-flight list, result queue).
module tb_mult_result_queue;

    localparam int BW = 32;
    localparam int ST = 8;
    localparam int TW = 5;
    localparam int DP = 8;

    logic          clk;
    logic          rst;
    logic          issueValid;
    logic [TW-1:0] issueTag;
    logic [BW-1:0] opA;
    logic [BW-1:0] opB;
    logic          wbReady;
    logic          forceDone;

    logic          issueReady;
    logic          startO;
    logic [BW-1:0] productI;
    logic          doneI;
    logic          wbValid;
    logic [BW-1:0] wbData;
    logic [TW-1:0] wbTag;
    logic          errO;

    mult_result_queue #(
        .BIT_WIDTH(BW),
        .STAGES(ST),
        .TAG_WIDTH(TW),
        .DEPTH(DP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .issue_valid_i(issueValid),
        .issue_tag_i(issueTag),
        .issue_ready_o(issueReady),
        .start_o(startO),
        .product_i(productI),
        .done_i(doneI),
        .wb_valid_o(wbValid),
        .wb_data_o(wbData),
        .wb_tag_o(wbTag),
        .wb_ready_i(wbReady),
        .err_o(errO)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural pipe_mult: fixed latency, no stall, shares reset.
    logic [ST-1:0] pmValid;
    logic [BW-1:0] pmProd [ST];

    always @(posedge clk) begin
        if (rst) begin
            pmValid <= '0;
        end else begin
            pmValid[0] <= startO;
            for (int i = 1; i < ST; i++) pmValid[i] <= pmValid[i-1];
        end
        pmProd[0] <= opA * opB;
        for (int i = 1; i < ST; i++) pmProd[i] <= pmProd[i-1];
    end

    assign doneI    = pmValid[ST-1] | forceDone;
    assign productI = pmProd[ST-1];

    // Transaction-level reference model.
    typedef struct {
        int            due;
        logic [BW-1:0] data;
        logic [TW-1:0] tag;
    } flight_t;

    typedef struct {
        logic [BW-1:0] data;
        logic [TW-1:0] tag;
    } res_t;

    flight_t inflight[$];
    res_t    fifoQ[$];
    int      reserved  = 0;
    int      edgeCount = 0;
    int      starts    = 0;
    int      pops      = 0;
    bit      errModel  = 1'b0;
    bit      lastFire  = 1'b0;

    int checks = 0;
    int errors = 0;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock cycle: check launch-side outputs mid-cycle, advance the model at
    // the edge, then check result-side outputs just after the edge.
    task automatic tick();
        bit            expReady;
        bit            issueFire;
        bit            popFire;
        bit            sampledForce;
        bit            due;
        logic [BW-1:0] prod;
        logic [TW-1:0] tag;
        flight_t       f;
        res_t          r;

        @(negedge clk);
        expReady = !rst && (reserved != DP);
        check("issue_ready", {63'd0, issueReady}, {63'd0, expReady});
        check("start", {63'd0, startO}, {63'd0, issueValid && expReady});
        issueFire    = issueValid && expReady;
        popFire      = !rst && (fifoQ.size() != 0) && wbReady;
        sampledForce = forceDone;
        prod         = opA * opB;
        tag          = issueTag;

        @(posedge clk);
        edgeCount++;
        lastFire = 1'b0;
        if (rst) begin
            inflight.delete();
            fifoQ.delete();
            reserved = 0;
            errModel = 1'b0;
        end else begin
            due = (inflight.size() != 0) && (inflight[0].due == edgeCount);
            if (popFire) begin
                void'(fifoQ.pop_front());
                pops++;
            end
            if (due) begin
                f = inflight.pop_front();
                r.data = f.data;
                r.tag  = f.tag;
                fifoQ.push_back(r);
            end
            if (sampledForce && !due) errModel = 1'b1;
            if (issueFire) begin
                f.due  = edgeCount + ST;
                f.data = prod;
                f.tag  = tag;
                inflight.push_back(f);
                starts++;
                lastFire = 1'b1;
            end
            reserved = reserved + int'(issueFire) - int'(popFire);
        end

        #1;
        check("wb_valid", {63'd0, wbValid}, {63'd0, fifoQ.size() != 0});
        check("err", {63'd0, errO}, {63'd0, errModel});
        if (fifoQ.size() != 0) begin
            check("wb_data", {32'd0, wbData}, {32'd0, fifoQ[0].data});
            check("wb_tag", {59'd0, wbTag}, {59'd0, fifoQ[0].tag});
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [TW-1:0] t,
                                 input logic [BW-1:0] a, input logic [BW-1:0] b);
        issueValid = v;
        issueTag   = t;
        opA        = a;
        opB        = b;
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        int guard;
        int startsBefore;
        int popsBefore;

        rst        = 1'b1;
        wbReady    = 1'b0;
        forceDone  = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);

        // Reset state.
        tick();
        tick();
        check("reset_wb_valid", {63'd0, wbValid}, 64'd0);
        check("reset_wb_data", {32'd0, wbData}, 64'd0);
        check("reset_wb_tag", {59'd0, wbTag}, 64'd0);
        check("reset_err", {63'd0, errO}, 64'd0);
        rst = 1'b0;

        // Single op: 2 x 3 with tag 3 appears STAGES+1 edges after launch.
        $display("[TB] single op");
        wbReady = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'd2, 32'd3);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST - 1) tick();
        check("single_early", {63'd0, wbValid}, 64'd0);
        tick();
        check("single_valid", {63'd0, wbValid}, 64'd1);
        check("single_data", {32'd0, wbData}, 64'd6);
        check("single_tag", {59'd0, wbTag}, 64'd3);
        check("single_err", {63'd0, errO}, 64'd0);
        tick();
        check("single_gone", {63'd0, wbValid}, 64'd0);

        // Back-to-back: 16 launches with tags 0..15 and random operands.
        $display("[TB] back-to-back");
        popsBefore = pops;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, TW'(i), $urandom, $urandom);
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!lastFire && guard < 50);
            check("b2b_issue_accepted", {63'd0, lastFire}, 64'd1);
        end
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST + 4) tick();
        check("b2b_pop_count", 64'(pops - popsBefore), 64'd16);

        // Backpressure: exactly DEPTH launches while writeback is stalled.
        $display("[TB] backpressure");
        wbReady      = 1'b0;
        startsBefore = starts;
        applyStimulus(1'b1, 5'd9, 32'd7, 32'd11);
        repeat (ST + DP + 4) tick();
        check("bp_start_count", 64'(starts - startsBefore), 64'(DP));
        check("bp_ready_low", {63'd0, issueReady}, 64'd0);
        popsBefore = pops;
        wbReady    = 1'b1;
        tick();
        check("bp_ready_resumes", {63'd0, issueReady}, 64'd1);
        applyStimulus(1'b0, '0, '0, '0);
        repeat (DP - 1) tick();
        check("bp_pop_count", 64'(pops - popsBefore), 64'(DP));
        repeat (ST + 4) tick();

        // Simultaneous launch and pop with one credit left.
        $display("[TB] simultaneous issue and pop");
        wbReady = 1'b0;
        for (int i = 0; i < DP - 1; i++) begin
            applyStimulus(1'b1, TW'(i + 20), $urandom, $urandom);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST + 2) tick();
        check("sim_ready_before", {63'd0, issueReady}, 64'd1);
        applyStimulus(1'b1, 5'd30, 32'd4, 32'd5);
        wbReady = 1'b1;
        tick();
        check("sim_ready_after", {63'd0, issueReady}, 64'd1);
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST + DP + 4) tick();

        // Protocol error: done with nothing in flight.
        $display("[TB] protocol error");
        forceDone = 1'b1;
        tick();
        forceDone = 1'b0;
        check("perr_set", {63'd0, errO}, 64'd1);
        check("perr_no_push", {63'd0, wbValid}, 64'd0);
        repeat (3) tick();
        check("perr_sticky", {63'd0, errO}, 64'd1);

        // Reset mid-flight: 2 results queued and 4 ops outstanding.
        $display("[TB] reset mid-flight");
        wbReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, TW'(i + 1), $urandom, $urandom);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST + 1) tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, TW'(i + 10), $urandom, $urandom);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wb_valid", {63'd0, wbValid}, 64'd0);
        check("rst_err", {63'd0, errO}, 64'd0);
        wbReady = 1'b1;
        applyStimulus(1'b1, 5'd7, 32'hFFFF_FFEC, 32'd5);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        repeat (ST) tick();
        check("rst_next_valid", {63'd0, wbValid}, 64'd1);
        check("rst_next_data", {32'd0, wbData}, {32'd0, 32'hFFFF_FF9C});
        check("rst_next_tag", {59'd0, wbTag}, 64'd7);
        repeat (ST + 2) tick();
        check("rst_no_stale", 64'(fifoQ.size()), 64'd0);

        // Randomized traffic against the reference model.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 3) != 0, TW'($urandom), $urandom, $urandom);
            wbReady = ($urandom % 4) != 0;
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        wbReady = 1'b1;
        repeat (ST + DP + 4) tick();
        check("final_empty", {63'd0, wbValid}, 64'd0);
        check("final_ready", {63'd0, issueReady}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
